// File: rtl/dev_fetch_pkg.sv
// Shared types for the instruction-fetch stage: FSM states, error codes, instruction size.
package pkg_fetch;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_READ = 2'd1,
    FETCH_DONE = 2'd2,
    FETCH_ERR  = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    FETCH_ERR_NONE    = 2'd0,
    FETCH_ERR_ALIGN   = 2'd1,
    FETCH_ERR_TIMEOUT = 2'd2
  } fetch_err_e;

  localparam int FETCH_BYTES = 4;
  localparam int IDX_W       = $clog2(FETCH_BYTES);

endpackage

// File: rtl/dev_fetch_if.sv
// Fetch-stage bus: CU request, byte-wide RAM read port and decoder-facing outputs.
interface dev_fetch_if #(
  parameter int ADDR_W = 16
) ();
  logic              fetch_start;
  logic [ADDR_W-1:0] pc;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic [31:0]       ir;
  logic              decode_en;
  logic              busy;
  logic              fetch_err;
  logic [1:0]        err_code;

  modport slave (
    input  fetch_start, pc, mem_ack, mem_rdata,
    output mem_req, mem_addr, ir, decode_en, busy, fetch_err, err_code
  );

  modport master (
    output fetch_start, pc, mem_ack, mem_rdata,
    input  mem_req, mem_addr, ir, decode_en, busy, fetch_err, err_code
  );
endinterface

// File: rtl/dev_fetch_wait_cnt.sv
// Saturating wait-cycle counter with synchronous clear; tc_o flags count == TIMEOUT-1.
module fetch_wait_cnt #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == TC_VAL);
endmodule

// File: rtl/dev_fetch.sv
// Instruction fetch: reads 4 big-endian bytes at pc into ir, pulses decode_en,
// flags misaligned pc or RAM timeout via fetch_err/err_code.
module dev_fetch
  import pkg_fetch::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  dev_fetch_if.slave  bus
);
  fetch_state_e      state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [31:0]       ir_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              decode_en_q;
  logic              fetch_err_q;
  fetch_err_e        err_code_q;

  logic start_ok, ack, wait_tc;

  assign start_ok = (state_q == FETCH_IDLE) && bus.fetch_start && (bus.pc[1:0] == 2'b00);
  assign ack      = (state_q == FETCH_READ) && bus.mem_ack;

  fetch_wait_cnt #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (start_ok || ack),
    .inc_i ((state_q == FETCH_READ) && !bus.mem_ack),
    .tc_o  (wait_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FETCH_IDLE;
      idx_q       <= '0;
      ir_q        <= 32'h0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      decode_en_q <= 1'b0;
      fetch_err_q <= 1'b0;
      err_code_q  <= FETCH_ERR_NONE;
    end else begin
      decode_en_q <= 1'b0;
      fetch_err_q <= 1'b0;
      case (state_q)
        FETCH_IDLE: begin
          if (bus.fetch_start) begin
            if (bus.pc[1:0] != 2'b00) begin
              state_q    <= FETCH_ERR;
              err_code_q <= FETCH_ERR_ALIGN;
            end else begin
              state_q    <= FETCH_READ;
              err_code_q <= FETCH_ERR_NONE;
              idx_q      <= '0;
              mem_req_q  <= 1'b1;
              mem_addr_q <= bus.pc;
            end
          end
        end
        FETCH_READ: begin
          if (bus.mem_ack) begin
            // Shift left so the byte at pc ends up in the opcode field ir[31:24].
            ir_q <= {ir_q[23:0], bus.mem_rdata};
            if (idx_q == IDX_W'(FETCH_BYTES - 1)) begin
              state_q     <= FETCH_DONE;
              mem_req_q   <= 1'b0;
              decode_en_q <= 1'b1;
            end else begin
              idx_q      <= idx_q + IDX_W'(1);
              mem_addr_q <= mem_addr_q + ADDR_W'(1);
            end
          end else if (wait_tc) begin
            state_q    <= FETCH_ERR;
            mem_req_q  <= 1'b0;
            err_code_q <= FETCH_ERR_TIMEOUT;
          end
        end
        FETCH_DONE: begin
          state_q <= FETCH_IDLE;
        end
        FETCH_ERR: begin
          state_q     <= FETCH_IDLE;
          fetch_err_q <= 1'b1;
        end
        default: state_q <= FETCH_IDLE;
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.ir        = ir_q;
  assign bus.decode_en = decode_en_q;
  assign bus.busy      = (state_q != FETCH_IDLE);
  assign bus.fetch_err = fetch_err_q;
  assign bus.err_code  = err_code_q;
endmodule

// File: tb/tb_dev_fetch.sv
// Directed bench for dev_fetch with a byte RAM model supporting wait states and ack cut-off.
module tb_dev_fetch;
  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  dev_fetch_if #(.ADDR_W(16)) bus ();

  dev_fetch #(
    .ADDR_W  (16),
    .TIMEOUT (8),
    .CNT_W   (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] ram [0:65535];
  int stall_cfg = 0;
  int ack_limit = 1000000;
  int stall_cnt = 0;
  int acks_seen = 0;

  assign bus.mem_ack   = bus.mem_req && (stall_cnt >= stall_cfg) && (acks_seen < ack_limit);
  assign bus.mem_rdata = ram[bus.mem_addr];

  always @(posedge clk) begin
    if (!bus.mem_req || bus.mem_ack) stall_cnt <= 0;
    else                             stall_cnt <= stall_cnt + 1;
    if (bus.mem_ack) acks_seen <= acks_seen + 1;
  end

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n_de;
  int de_cyc;
  int err_cyc;

  initial begin
    bus.fetch_start = 1'b0;
    bus.pc          = 16'h0;
    ram[16'h0100] = 8'h11; ram[16'h0101] = 8'h23; ram[16'h0102] = 8'h40; ram[16'h0103] = 8'h00;
    ram[16'h0000] = 8'h05; ram[16'h0001] = 8'hA1; ram[16'h0002] = 8'hB2; ram[16'h0003] = 8'hC3;
    ram[16'hFFFC] = 8'hDE; ram[16'hFFFD] = 8'hAD; ram[16'hFFFE] = 8'hBE; ram[16'hFFFF] = 8'hEF;

    // 1: reset then idle
    repeat (3) tick();
    chk("rst_ir", bus.ir, 32'h0);
    chk("rst_err_code", bus.err_code, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    rst = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk($sformatf("idle_busy_c%0d", c), bus.busy, 0);
      chk($sformatf("idle_mem_req_c%0d", c), bus.mem_req, 0);
      chk($sformatf("idle_decode_en_c%0d", c), bus.decode_en, 0);
    end
    chk("idle_ir", bus.ir, 32'h0);

    // 2: zero-wait fetch at 0x0100
    bus.fetch_start = 1'b1; bus.pc = 16'h0100;
    for (int c = 1; c <= 4; c++) begin
      tick();
      bus.fetch_start = 1'b0;
      chk($sformatf("zw_mem_req_c%0d", c), bus.mem_req, 1);
      chk($sformatf("zw_mem_addr_c%0d", c), bus.mem_addr, 32'h0100 + c - 1);
      chk($sformatf("zw_decode_en_c%0d", c), bus.decode_en, 0);
    end
    tick();
    chk("zw_decode_en_c5", bus.decode_en, 1);
    chk("zw_mem_req_c5", bus.mem_req, 0);
    chk("zw_ir", bus.ir, 32'h11234000);
    chk("zw_err_code", bus.err_code, 0);
    tick();
    chk("zw_decode_en_c6", bus.decode_en, 0);
    chk("zw_busy_c6", bus.busy, 0);

    // 3: two wait states per byte, stray fetch_start at cycle 3
    stall_cfg = 2;
    n_de = 0; de_cyc = -1;
    bus.fetch_start = 1'b1; bus.pc = 16'h0100;
    for (int c = 1; c <= 18; c++) begin
      tick();
      bus.fetch_start = (c == 3);
      bus.pc = (c == 3) ? 16'h0200 : 16'h0100;
      if (bus.decode_en) begin n_de++; de_cyc = c; end
      if (c == 2) chk("ws_addr_stable_c2", bus.mem_addr, 32'h0100);
      if (c == 4) chk("ws_addr_c4", bus.mem_addr, 32'h0101);
      if (c == 13) chk("ws_ir", bus.ir, 32'h11234000);
    end
    chk("ws_decode_count", n_de, 1);
    chk("ws_decode_cycle", de_cyc, 13);
    stall_cfg = 0;

    // 4: misaligned pc
    bus.fetch_start = 1'b1; bus.pc = 16'h0102;
    tick();
    bus.fetch_start = 1'b0;
    chk("mis_mem_req_c1", bus.mem_req, 0);
    chk("mis_err_c1", bus.fetch_err, 0);
    tick();
    chk("mis_err_c2", bus.fetch_err, 1);
    chk("mis_err_code", bus.err_code, 1);
    chk("mis_mem_req_c2", bus.mem_req, 0);
    chk("mis_ir", bus.ir, 32'h11234000);
    tick();
    chk("mis_err_c3", bus.fetch_err, 0);
    chk("mis_err_code_hold", bus.err_code, 1);

    // 5: timeout after the first byte (TIMEOUT=8)
    ack_limit = acks_seen + 1;
    n_de = 0; err_cyc = -1;
    bus.fetch_start = 1'b1; bus.pc = 16'h0000;
    for (int c = 1; c <= 40 && err_cyc < 0; c++) begin
      tick();
      bus.fetch_start = 1'b0;
      if (c == 1) chk("to_err_code_clr", bus.err_code, 0);
      if (bus.decode_en) n_de++;
      if (bus.fetch_err) err_cyc = c;
    end
    chk("to_err_cycle", err_cyc, 11);
    chk("to_err_code", bus.err_code, 2);
    chk("to_decode_none", n_de, 0);
    chk("to_ir_partial", bus.ir, 32'h23400005);
    chk("to_mem_req", bus.mem_req, 0);
    ack_limit = 1000000;
    tick();
    bus.fetch_start = 1'b1; bus.pc = 16'h0000;
    tick();
    bus.fetch_start = 1'b0;
    chk("to_good_err_code", bus.err_code, 0);
    repeat (4) tick();
    chk("to_good_decode_en", bus.decode_en, 1);
    chk("to_good_ir", bus.ir, 32'h05A1B2C3);

    // 6: reset during the third byte, then address wrap
    tick();
    bus.fetch_start = 1'b1; bus.pc = 16'h0100;
    stall_cfg = 1;
    repeat (5) begin
      tick();
      bus.fetch_start = 1'b0;
    end
    chk("mid_addr_byte2", bus.mem_addr, 32'h0102);
    #2 rst = 1'b0;
    #1;
    chk("mid_mem_req_async", bus.mem_req, 0);
    chk("mid_ir_async", bus.ir, 32'h0);
    chk("mid_busy_async", bus.busy, 0);
    tick();
    rst = 1'b1;
    stall_cfg = 0;
    n_de = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (bus.decode_en || bus.fetch_err) n_de++;
    end
    chk("mid_no_pulse", n_de, 0);
    chk("mid_ir_after", bus.ir, 32'h0);

    bus.fetch_start = 1'b1; bus.pc = 16'hFFFC;
    for (int c = 1; c <= 4; c++) begin
      tick();
      bus.fetch_start = 1'b0;
      chk($sformatf("wrap_addr_c%0d", c), bus.mem_addr, 32'hFFFC + c - 1);
    end
    tick();
    chk("wrap_decode_en", bus.decode_en, 1);
    chk("wrap_ir", bus.ir, 32'hDEADBEEF);
    chk("wrap_err_code", bus.err_code, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/dev_fetch.md
Name: dev_fetch

Overview:
Instruction-fetch stage directly upstream of the instruction decoder. On a fetch request from the control unit it reads one 32-bit big-endian instruction from byte-wide RAM at the current PC. It assembles the instruction into the instruction register and pulses the decoder enable for exactly one cycle. It also detects misaligned PCs and memory timeouts and reports them to the control unit.

Parameters:
ADDR_W, 16, width of PC and RAM byte address
TIMEOUT, 255, max cycles to wait for mem_ack per byte before aborting (1..2^CNT_W-1)
CNT_W, 8, width of the wait-cycle counter

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  asynchronous, active-low reset (asserted when 0)
fetch_start  in  1  one-cycle request from CU: fetch instruction at pc
pc  in  ADDR_W  instruction address, sampled with fetch_start
mem_req  out  1  byte read request to RAM
mem_addr  out  ADDR_W  byte address of current read
mem_ack  in  1  RAM: mem_rdata valid this cycle (sampled at posedge while mem_req=1)
mem_rdata  in  8  RAM read byte
ir  out  32  instruction register, feeds decoder ir input
decode_en  out  1  one-cycle pulse: ir newly valid, drives decoder en
busy  out  1  fetch in progress (state != IDLE)
fetch_err  out  1  one-cycle pulse: fetch aborted
err_code  out  2  0 none, 1 misaligned pc, 2 timeout; held until next fetch_start

Behaviour:
- Reset (rst=0, async): state=IDLE, ir=32'h0 (op 0x00, decodes to all-NOP), byte index=0, wait counter=0, decode_en=0, fetch_err=0, err_code=0, mem_req=0, mem_addr=0.
- States: IDLE, READ, DONE, ERR.
- IDLE: on fetch_start=1:
  - pc[1:0]!=0: go to ERR with err_code=1; no memory access.
  - otherwise: latch base=pc, idx=0, wait=0, err_code=0; go to READ.
  - fetch_start outside IDLE is ignored (no queuing).
- READ:
  - mem_req=1, mem_addr=base+idx (ADDR_W-bit wrap-around permitted, no error); addr stable until ack.
  - On mem_ack: ir <= {ir[23:0], mem_rdata}; wait <= 0. If idx==3, go to DONE, else idx++.
  - Result: byte at pc lands in ir[31:24] (opcode); byte at pc+3 lands in ir[7:0].
  - No ack: wait++. If wait reaches TIMEOUT-1 with still no ack, go to ERR with err_code=2.
  - ir is not restored on timeout: a partially shifted ir is allowed, and decode_en is not pulsed.
- DONE: decode_en=1 for this single cycle, mem_req=0, then IDLE. ir is stable from entry to DONE until the next fetch's first ack.
- ERR: fetch_err=1 for this single cycle, then IDLE; err_code holds.
- Latency: with zero-wait RAM (mem_ack asserted the first cycle mem_req is high), fetch_start at cycle 0 → mem_req cycles 1-4 → decode_en at cycle 5. Each RAM wait state adds 1 cycle.
- mem_ack while mem_req=0 is ignored.
- Reset mid-fetch aborts immediately: no decode_en and no fetch_err is produced.
- busy=1 in READ, DONE and ERR.

Decomposition:
- pkg_fetch holds:
  - state enum FETCH_IDLE, FETCH_READ, FETCH_DONE, FETCH_ERR
  - err enum FETCH_ERR_NONE=0, FETCH_ERR_ALIGN=1, FETCH_ERR_TIMEOUT=2
  - FETCH_BYTES=4
- One sub-module is natural: fetch_wait_cnt, a CNT_W-bit saturating counter with clear, increment and terminal-count (==TIMEOUT-1) output, reused later by the bus stage.

Test Plan:
1. Reset then idle: rst low 3 cycles, high → ir=0, decode_en=0, busy=0, mem_req=0 for 10 cycles.
2. Zero-wait fetch: RAM[0x0100..0x0103]=11 23 40 00, pulse fetch_start with pc=0x0100 → mem_addr 0x0100,0x0101,0x0102,0x0103 on cycles 1-4; decode_en only at cycle 5; ir=32'h11234000.
3. Wait states: same as test 2 with 2 stall cycles per byte → decode_en at cycle 13, ir identical. A fetch_start pulsed at cycle 3 is ignored: exactly one decode_en.
4. Misaligned: pc=0x0102 → fetch_err pulse at cycle 2, err_code=1, mem_req never asserted, ir unchanged.
5. Timeout: TIMEOUT=8, RAM acks byte 0 (0x05) only, then silent → fetch_err pulse, err_code=2, no decode_en. A following good fetch at pc=0x0000 yields err_code=0 and a correct ir.
6. Reset mid-fetch: rst low during the 3rd byte → ir=0, mem_req=0 immediately (async, before the next clock edge), no decode_en after release. Address wrap: pc=0xFFFC → mem_addr 0xFFFC..0xFFFF, normal decode_en.
